// File: rtl/ro_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator
// frequency measurement block.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        DONE
    } meas_state_e;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_W         = 16;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_SETTLE_CYCLES = 8;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchroniser chain for an asynchronous level plus a
// maskable single-cycle rising-edge pulse.
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic en,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the async level in; prev always tracks the synced value
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and previous-sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = en & sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator edge counter: enable, settle, count over a
// programmable clk window, return result by valid/ready.
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_W         = DEF_WIN_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             osc_enable,
    input  logic             osc_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overflow
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    meas_state_e      state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic             rise;

    sync_rise_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(osc_in),
        .en      (state_q == COUNT),
        .rise    (rise)
    );

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (window_len != '0) begin
                        win_d    = window_len;
                        settle_d = SET_W'(SETTLE_CYCLES);
                        state_d  = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                settle_d = settle_q - SET_W'(1);
                if (settle_q == SET_W'(1)) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (rise) begin
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                win_d = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (count_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        en_d    = (state_d == SETTLE) || (state_d == COUNT);
        valid_d = (state_d == DONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
        end
    end

    assign busy        = busy_q;
    assign osc_enable  = en_q;
    assign count       = cnt_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench: two counters (16-bit and 4-bit) share stimulus,
// each driven by its own oscillator model.
module tb_ro_freq_counter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] window_len;
    logic        count_ready;

    logic        busy16, en16, osc16, valid16, ovf16;
    logic [15:0] count16;
    logic        busy4, en4, osc4, valid4, ovf4;
    logic [3:0]  count4;

    int osc_mode;
    int ph16;
    int ph4;
    int n_assert;
    int n_fail;
    int lat;
    int en_cyc;
    int saw;

    ro_freq_counter dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .window_len (window_len),
        .busy       (busy16),
        .osc_enable (en16),
        .osc_in     (osc16),
        .count      (count16),
        .count_valid(valid16),
        .count_ready(count_ready),
        .overflow   (ovf16)
    );

    ro_freq_counter #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .window_len (window_len),
        .busy       (busy4),
        .osc_enable (en4),
        .osc_in     (osc4),
        .count      (count4),
        .count_valid(valid4),
        .count_ready(count_ready),
        .overflow   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator period 10 clk for the 16-bit counter
    always @(negedge clk) begin
        if (osc_mode == 1 && en16) begin
            if (ph16 == 4) begin
                osc16 <= ~osc16;
                ph16  <= 0;
            end else begin
                ph16 <= ph16 + 1;
            end
        end else begin
            osc16 <= 1'b0;
            ph16  <= 0;
        end
    end

    // Oscillator period 4 clk for the 4-bit counter
    always @(negedge clk) begin
        if (osc_mode == 1 && en4) begin
            if (ph4 == 1) begin
                osc4 <= ~osc4;
                ph4  <= 0;
            end else begin
                ph4 <= ph4 + 1;
            end
        end else begin
            osc4 <= 1'b0;
            ph4  <= 0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_meas(input logic [15:0] w);
        window_len = w;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        lat    = 1;
        en_cyc = 0;
        while (!valid16 && lat < limit) begin
            if (en16) en_cyc++;
            step(1);
            lat++;
        end
    endtask

    task automatic ack(input string tag);
        count_ready = 1'b1;
        step(1);
        count_ready = 1'b0;
        check(tag, {30'd0, valid16, valid4}, 32'd0);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        osc_mode    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        window_len  = '0;
        count_ready = 1'b0;
        step(3);

        check("rst_busy",  {30'd0, busy16, busy4}, 32'd0);
        check("rst_en",    {30'd0, en16, en4}, 32'd0);
        check("rst_cnt16", count16, 32'd0);
        check("rst_cnt4",  count4, 32'd0);
        check("rst_valid", {30'd0, valid16, valid4}, 32'd0);
        check("rst_ovf",   {30'd0, ovf16, ovf4}, 32'd0);
        rst = 1'b0;
        step(2);

        osc_mode = 1;
        start_meas(16'd100);
        wait_valid(200);
        check("t1_latency", lat, 32'd109);
        check("t1_en_cycles", en_cyc, 32'd108);
        check("t1_cnt16_range",
              (count16 >= 9 && count16 <= 11), 32'd1);
        check("t1_ovf16", ovf16, 32'd0);
        check("t1_valid4", valid4, 32'd1);
        check("t1_cnt4_sat", count4, 32'd15);
        check("t1_ovf4", ovf4, 32'd1);
        check("t1_en_off", {30'd0, en16, en4}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            start = (i == 5 || i == 12);
            check("hold_valid", {30'd0, valid16, valid4}, 32'd3);
            check("hold_busy", busy16, 32'd1);
            check("hold_cnt4", count4, 32'd15);
            check("hold_ovf4", ovf4, 32'd1);
            check("hold_cnt16",
                  (count16 >= 9 && count16 <= 11), 32'd1);
            check("hold_en", en16, 32'd0);
            step(1);
        end
        start       = 1'b0;
        count_ready = 1'b1;
        start       = 1'b1;
        step(1);
        count_ready = 1'b0;
        start       = 1'b0;
        check("ack_valid", {30'd0, valid16, valid4}, 32'd0);
        check("ack_start_ignored", {30'd0, busy16, busy4}, 32'd0);

        start_meas(16'd0);
        check("w0_valid", valid16, 32'd1);
        check("w0_busy", busy16, 32'd1);
        check("w0_en", {30'd0, en16, en4}, 32'd0);
        check("w0_cnt16", count16, 32'd0);
        check("w0_cnt4", count4, 32'd0);
        check("w0_ovf", {30'd0, ovf16, ovf4}, 32'd0);
        ack("w0_ack");

        start_meas(16'd100);
        step(30);
        check("rstmid_en_before", en16, 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rstmid_en", {30'd0, en16, en4}, 32'd0);
        check("rstmid_busy", {30'd0, busy16, busy4}, 32'd0);
        check("rstmid_cnt16", count16, 32'd0);
        check("rstmid_cnt4", count4, 32'd0);
        check("rstmid_ovf", {30'd0, ovf16, ovf4}, 32'd0);
        saw = 0;
        for (int i = 0; i < 150; i++) begin
            if (valid16 || valid4 || en16) saw++;
            step(1);
        end
        check("rstmid_no_valid", saw, 32'd0);

        start_meas(16'd50);
        wait_valid(200);
        check("w50_latency", lat, 32'd59);
        check("w50_en_cycles", en_cyc, 32'd58);
        check("w50_cnt16_range",
              (count16 >= 4 && count16 <= 6), 32'd1);
        check("w50_cnt4_range",
              (count4 >= 11 && count4 <= 14), 32'd1);
        check("w50_ovf", {30'd0, ovf16, ovf4}, 32'd0);
        ack("w50_ack");

        osc_mode = 0;
        start_meas(16'd1000);
        wait_valid(1100);
        check("dead_latency", lat, 32'd1009);
        check("dead_cnt16", count16, 32'd0);
        check("dead_cnt4", count4, 32'd0);
        check("dead_ovf", {30'd0, ovf16, ovf4}, 32'd0);
        ack("dead_ack");

        start_meas(16'd1);
        wait_valid(50);
        check("w1_latency", lat, 32'd10);
        check("w1_en_cycles", en_cyc, 32'd9);
        check("w1_cnt16", count16, 32'd0);
        ack("w1_ack");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
